// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the TX arbiter, its two requesters and the RX side.
// master = arbiter side, slave = requester/environment side.
interface tx_arbiter_if #(
    parameter int NSHIFT   = 2,
    parameter int CMD_BITS = 3,
    parameter int CW       = 4
);
    logic                sc_cmd_valid;
    logic [CMD_BITS-1:0] sc_command;
    logic                sc_has_payload;
    logic                sc_reply_wanted;
    logic                sc_reserve;
    logic [NSHIFT-1:0]   sc_data;
    logic                sc_cmd_started;
    logic                sc_data_next;

    logic                pf_cmd_valid;
    logic [CMD_BITS-1:0] pf_command;
    logic                pf_has_payload;
    logic                pf_reply_wanted;
    logic [NSHIFT-1:0]   pf_data;
    logic                pf_cmd_started;
    logic                pf_data_next;

    logic                rx_done;

    logic [NSHIFT-1:0]   tx_pins;
    logic                tx_active;
    logic [CW-1:0]       tx_counter;
    logic                tx_done;
    logic                tx_owner;
    logic                reply_pending;

    modport master (
        input  sc_cmd_valid, sc_command, sc_has_payload, sc_reply_wanted, sc_reserve, sc_data,
        output sc_cmd_started, sc_data_next,
        input  pf_cmd_valid, pf_command, pf_has_payload, pf_reply_wanted, pf_data,
        output pf_cmd_started, pf_data_next,
        input  rx_done,
        output tx_pins, tx_active, tx_counter, tx_done, tx_owner, reply_pending
    );

    modport slave (
        output sc_cmd_valid, sc_command, sc_has_payload, sc_reply_wanted, sc_reserve, sc_data,
        input  sc_cmd_started, sc_data_next,
        output pf_cmd_valid, pf_command, pf_has_payload, pf_reply_wanted, pf_data,
        input  pf_cmd_started, pf_data_next,
        output rx_done,
        input  tx_pins, tx_active, tx_counter, tx_done, tx_owner, reply_pending
    );
endinterface

// File: rtl/tx_arbiter.sv
// Shares the serial TX pins between prefetcher (pf) and scheduler (sc): one grant
// per frame, header plus optional payload, single outstanding reply tracking.
//
// state | meaning
// IDLE  | pins low, grant evaluated combinationally on requests
// H0    | header beat 0: start marker plus command MSB
// H1    | header beat 1: command low bits; frame ends here without payload
// PAY   | payload beats from the owner's data, one chunk per cycle
module tx_arbiter #(
    parameter int NSHIFT         = 2,
    parameter int CMD_BITS       = 3,
    parameter int PAYLOAD_CYCLES = 8
) (
    input logic          clk,
    input logic          reset,
    tx_arbiter_if.master bus
);
    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, H0, H1, PAY} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       pay_left, pay_left_nxt;
    logic [CMD_BITS-1:0] cmd_q;
    logic                pay_q;
    logic                owner_q;
    logic                reply_pending_q;

    logic                reply_clear;
    logic                elig_sc, elig_pf;
    logic                grant_sc, grant_pf, grant, grant_rw;

    logic [NSHIFT-1:0]   pins;
    logic [CW-1:0]       counter;
    logic                active, done, data_next;

    // A reply-wanting command may go out once the pending reply completes, even in the same cycle.
    assign reply_clear = !reply_pending_q || bus.rx_done;
    assign elig_sc     = bus.sc_cmd_valid && (!bus.sc_reply_wanted || reply_clear);
    assign elig_pf     = bus.pf_cmd_valid && !bus.sc_reserve && (!bus.pf_reply_wanted || reply_clear);
    assign grant_sc    = (state == IDLE) && !reset && elig_sc;
    assign grant_pf    = (state == IDLE) && !reset && !elig_sc && elig_pf;
    assign grant       = grant_sc || grant_pf;
    assign grant_rw    = grant_sc ? bus.sc_reply_wanted : bus.pf_reply_wanted;

    always_comb begin
        state_nxt    = state;
        pay_left_nxt = pay_left;
        pins         = '0;
        counter      = '0;
        active       = 1'b0;
        done         = 1'b0;
        data_next    = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = H0;
            end
            H0: begin
                active    = 1'b1;
                pins      = NSHIFT'({1'b1, cmd_q[CMD_BITS-1]});
                state_nxt = H1;
            end
            H1: begin
                active       = 1'b1;
                pins         = cmd_q[NSHIFT-1:0];
                pay_left_nxt = CW'(PAYLOAD_CYCLES - 1);
                if (pay_q) begin
                    state_nxt = PAY;
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PAY: begin
                active    = 1'b1;
                data_next = 1'b1;
                pins      = owner_q ? bus.sc_data : bus.pf_data;
                counter   = CW'(PAYLOAD_CYCLES - 1) - pay_left;
                if (pay_left == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    pay_left_nxt = pay_left - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pay_left        <= '0;
            cmd_q           <= '0;
            pay_q           <= 1'b0;
            owner_q         <= 1'b0;
            reply_pending_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pay_left <= pay_left_nxt;
            if (grant) begin
                cmd_q   <= grant_sc ? bus.sc_command : bus.pf_command;
                pay_q   <= grant_sc ? bus.sc_has_payload : bus.pf_has_payload;
                owner_q <= grant_sc;
            end
            // A new reply-wanting grant outranks a completing reply.
            if (grant && grant_rw)
                reply_pending_q <= 1'b1;
            else if (bus.rx_done)
                reply_pending_q <= 1'b0;
        end
    end

    assign bus.sc_cmd_started = grant_sc;
    assign bus.pf_cmd_started = grant_pf;
    assign bus.sc_data_next   = data_next && owner_q;
    assign bus.pf_data_next   = data_next && !owner_q;
    assign bus.tx_pins        = pins;
    assign bus.tx_active      = active;
    assign bus.tx_counter     = counter;
    assign bus.tx_done        = done;
    assign bus.tx_owner       = owner_q;
    assign bus.reply_pending  = reply_pending_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: frame-level model checked every cycle plus pinned literals.
`timescale 1ns/1ps
module tb_tx_arbiter;
    localparam int PC = 8;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    int t1 = -1000, t2 = -1000, t3 = -1000, t3r = -1000;
    int t4s = -1000, t4r = -1000, t5 = -1000, t6x = -1000, t6n = -1000;

    tx_arbiter_if #(.NSHIFT(2), .CMD_BITS(3), .CW(4)) bus();

    tx_arbiter #(.NSHIFT(2), .CMD_BITS(3), .PAYLOAD_CYCLES(PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Payload sources: sc counts up, pf counts down, changing every cycle.
    initial begin
        bus.sc_data = 2'd0;
        bus.pf_data = 2'd3;
        forever begin
            @(posedge clk);
            #1;
            bus.sc_data = bus.sc_data + 2'd1;
            bus.pf_data = bus.pf_data - 2'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame model: beat -1 is idle, beat 0/1 are header, beat 2.. is payload.
    int         m_beat = -1;
    logic       m_owner = 1'b0;
    logic       m_pay = 1'b0;
    logic       m_rp = 1'b0;
    logic [2:0] m_cmd = 3'b000;

    int         e_pins, e_cnt, e_active, e_done, e_owner, e_rp;
    int         e_scs, e_pfs, e_scn, e_pfn, len;
    logic       elig_sc, elig_pf, g_sc, g_pf, g_rw;

    always @(negedge clk) begin
        e_pins = 0; e_cnt = 0; e_active = 0; e_done = 0; e_owner = 0; e_rp = 0;
        e_scs = 0; e_pfs = 0; e_scn = 0; e_pfn = 0;
        g_sc = 1'b0; g_pf = 1'b0; g_rw = 1'b0;
        if (!reset) begin
            e_owner = int'(m_owner);
            e_rp    = int'(m_rp);
            if (m_beat < 0) begin
                elig_sc = bus.sc_cmd_valid && (!bus.sc_reply_wanted || !m_rp || bus.rx_done);
                elig_pf = bus.pf_cmd_valid && !bus.sc_reserve &&
                          (!bus.pf_reply_wanted || !m_rp || bus.rx_done);
                g_sc  = elig_sc;
                g_pf  = !elig_sc && elig_pf;
                e_scs = int'(g_sc);
                e_pfs = int'(g_pf);
            end else begin
                len      = m_pay ? 2 + PC : 2;
                e_active = 1;
                e_done   = int'(m_beat == len - 1);
                if (m_beat == 0)      e_pins = 2 + int'(m_cmd[2]);
                else if (m_beat == 1) e_pins = int'(m_cmd) % 4;
                else begin
                    e_pins = m_owner ? int'(bus.sc_data) : int'(bus.pf_data);
                    e_cnt  = m_beat - 2;
                    e_scn  = int'(m_owner);
                    e_pfn  = int'(!m_owner);
                end
            end
        end

        chk("pins",          int'(bus.tx_pins),        e_pins);
        chk("counter",       int'(bus.tx_counter),     e_cnt);
        chk("active",        int'(bus.tx_active),      e_active);
        chk("done",          int'(bus.tx_done),        e_done);
        chk("owner",         int'(bus.tx_owner),       e_owner);
        chk("reply_pending", int'(bus.reply_pending),  e_rp);
        chk("sc_started",    int'(bus.sc_cmd_started), e_scs);
        chk("pf_started",    int'(bus.pf_cmd_started), e_pfs);
        chk("sc_data_next",  int'(bus.sc_data_next),   e_scn);
        chk("pf_data_next",  int'(bus.pf_data_next),   e_pfn);

        // Hand-computed anchors for the directed scenarios.
        if (cyc == t1)      chk("t1_sc_started", int'(bus.sc_cmd_started), 1);
        if (cyc == t1 + 1)  chk("t1_h0_pins",    int'(bus.tx_pins), 3);
        if (cyc == t1 + 2)  chk("t1_h1_pins",    int'(bus.tx_pins), 1);
        if (cyc == t1 + 3)  chk("t1_cnt_first",  int'(bus.tx_counter), 0);
        if (cyc == t1 + 10) begin
            chk("t1_cnt_last", int'(bus.tx_counter), 7);
            chk("t1_done",     int'(bus.tx_done), 1);
        end
        if (cyc == t1 + 11) chk("t1_idle_after", int'(bus.tx_active), 0);
        if (cyc == t2) begin
            chk("t2_sc_wins",  int'(bus.sc_cmd_started), 1);
            chk("t2_pf_loses", int'(bus.pf_cmd_started), 0);
        end
        if (cyc == t2 + 10) chk("t2_sc_done",      int'(bus.tx_done), 1);
        if (cyc == t2 + 11) chk("t2_pf_next_idle", int'(bus.pf_cmd_started), 1);
        if (cyc == t3)      chk("t3_reserved",     int'(bus.pf_cmd_started), 0);
        if (cyc == t3r)     chk("t3_released",     int'(bus.pf_cmd_started), 1);
        if (cyc == t4s) begin
            chk("t4_sc_stalled", int'(bus.sc_cmd_started), 0);
            chk("t4_rp_set",     int'(bus.reply_pending), 1);
        end
        if (cyc == t4r)     chk("t4_rx_grant",  int'(bus.sc_cmd_started), 1);
        if (cyc == t4r + 1) chk("t4_rp_kept",   int'(bus.reply_pending), 1);
        if (cyc == t5 + 1)  chk("t5_h0_pins",   int'(bus.tx_pins), 3);
        if (cyc == t5 + 2) begin
            chk("t5_h1_pins", int'(bus.tx_pins), 2);
            chk("t5_h1_done", int'(bus.tx_done), 1);
        end
        if (cyc == t5 + 3)  chk("t5_idle_after", int'(bus.tx_active), 0);
        if (cyc == t6x) begin
            chk("t6_rst_active", int'(bus.tx_active), 0);
            chk("t6_rst_pins",   int'(bus.tx_pins), 0);
            chk("t6_rst_rp",     int'(bus.reply_pending), 0);
        end
        if (cyc == t6n)     chk("t6_after_rst", int'(bus.sc_cmd_started), 1);

        if (reset) begin
            m_beat = -1; m_owner = 1'b0; m_pay = 1'b0; m_rp = 1'b0; m_cmd = 3'b000;
        end else if (m_beat < 0) begin
            if (g_sc || g_pf) begin
                m_owner = g_sc;
                m_cmd   = g_sc ? bus.sc_command : bus.pf_command;
                m_pay   = g_sc ? bus.sc_has_payload : bus.pf_has_payload;
                g_rw    = g_sc ? bus.sc_reply_wanted : bus.pf_reply_wanted;
                m_beat  = 0;
            end
            if ((g_sc || g_pf) && g_rw) m_rp = 1'b1;
            else if (bus.rx_done)       m_rp = 1'b0;
        end else begin
            m_beat = (e_done != 0) ? -1 : m_beat + 1;
            if (bus.rx_done) m_rp = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.sc_cmd_valid    = 1'b0;
        bus.sc_command      = 3'b000;
        bus.sc_has_payload  = 1'b0;
        bus.sc_reply_wanted = 1'b0;
        bus.sc_reserve      = 1'b0;
        bus.pf_cmd_valid    = 1'b0;
        bus.pf_command      = 3'b000;
        bus.pf_has_payload  = 1'b0;
        bus.pf_reply_wanted = 1'b0;
        bus.rx_done         = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // sc frame with payload on an idle bus
        bus.sc_command = 3'b101; bus.sc_has_payload = 1'b1; bus.sc_reply_wanted = 1'b0;
        bus.sc_cmd_valid = 1'b1;
        t1 = cyc;
        tick();
        bus.sc_cmd_valid = 1'b0;
        repeat (12) tick();

        // simultaneous requests: sc first, pf in the first idle cycle after
        bus.sc_command = 3'b010; bus.sc_has_payload = 1'b1; bus.sc_reply_wanted = 1'b0;
        bus.pf_command = 3'b111; bus.pf_has_payload = 1'b0; bus.pf_reply_wanted = 1'b0;
        bus.sc_cmd_valid = 1'b1; bus.pf_cmd_valid = 1'b1;
        t2 = cyc;
        tick();
        bus.sc_cmd_valid = 1'b0;
        repeat (10) tick();
        tick();
        bus.pf_cmd_valid = 1'b0;
        repeat (4) tick();

        // reserve blocks pf until released
        bus.sc_reserve = 1'b1;
        bus.pf_command = 3'b011; bus.pf_has_payload = 1'b1; bus.pf_reply_wanted = 1'b0;
        bus.pf_cmd_valid = 1'b1;
        t3 = cyc;
        repeat (3) tick();
        bus.sc_reserve = 1'b0;
        t3r = cyc;
        tick();
        bus.pf_cmd_valid = 1'b0;
        repeat (12) tick();

        // outstanding reply stalls a second reply-wanting command until rx_done
        bus.pf_command = 3'b100; bus.pf_has_payload = 1'b0; bus.pf_reply_wanted = 1'b1;
        bus.pf_cmd_valid = 1'b1;
        tick();
        bus.pf_cmd_valid = 1'b0;
        bus.sc_command = 3'b001; bus.sc_has_payload = 1'b0; bus.sc_reply_wanted = 1'b1;
        bus.sc_cmd_valid = 1'b1;
        repeat (2) tick();
        t4s = cyc;
        repeat (2) tick();
        bus.rx_done = 1'b1;
        t4r = cyc;
        tick();
        bus.rx_done = 1'b0;
        bus.sc_cmd_valid = 1'b0;
        repeat (4) tick();
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        tick();
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        repeat (2) tick();

        // header-only frame
        bus.sc_command = 3'b110; bus.sc_has_payload = 1'b0; bus.sc_reply_wanted = 1'b0;
        bus.sc_cmd_valid = 1'b1;
        t5 = cyc;
        tick();
        bus.sc_cmd_valid = 1'b0;
        repeat (4) tick();

        // reset in the fourth payload cycle of a reply-wanting frame
        bus.pf_command = 3'b101; bus.pf_has_payload = 1'b1; bus.pf_reply_wanted = 1'b1;
        bus.pf_cmd_valid = 1'b1;
        tick();
        bus.pf_cmd_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        t6x = cyc;
        tick();
        reset = 1'b0;
        tick();
        bus.sc_command = 3'b011; bus.sc_has_payload = 1'b0; bus.sc_reply_wanted = 1'b0;
        bus.sc_cmd_valid = 1'b1;
        t6n = cyc;
        tick();
        bus.sc_cmd_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Owns the serial TX pins and shares them between two requesters: the instruction prefetcher (pf) and the decoder/scheduler (sc).
- Grants one requester per frame and serializes a command header followed by an optional payload, NSHIFT bits per cycle.
- Drives the tx_* handshake signals seen by the scheduler.
- Tracks a single outstanding reply so that a second reply-wanting command is not issued before the RX side completes.

Parameters:
NSHIFT, 2, bits per TX cycle; header layout below fixed for NSHIFT=2
CMD_BITS, 3, command width (TX_CMD_BITS)
PAYLOAD_CYCLES, 8, payload length in cycles for commands with payload
CW, $clog2(PAYLOAD_CYCLES)+1, width of tx_counter (derived localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
sc_cmd_valid  in  1  scheduler requests a frame
sc_command  in  CMD_BITS  scheduler command
sc_has_payload  in  1  scheduler frame carries a payload
sc_reply_wanted  in  1  scheduler frame expects an RX reply
sc_reserve  in  1  scheduler reserve_tx: blocks new pf grants
sc_data  in  NSHIFT  scheduler payload chunk
sc_cmd_started  out  1  pulse: scheduler frame granted
sc_data_next  out  1  pulse: sc_data consumed this cycle
pf_cmd_valid  in  1  prefetch requests a frame
pf_command  in  CMD_BITS  prefetch command
pf_has_payload  in  1  prefetch frame carries a payload
pf_reply_wanted  in  1  prefetch frame expects a reply
pf_data  in  NSHIFT  prefetch payload chunk
pf_cmd_started  out  1  pulse: prefetch frame granted
pf_data_next  out  1  pulse: pf_data consumed
rx_done  in  1  pulse: outstanding reply fully received
tx_pins  out  NSHIFT  serial output
tx_active  out  1  frame in progress (H0..last cycle)
tx_counter  out  CW  payload cycle index
tx_done  out  1  pulse: last cycle of frame
tx_owner  out  1  0 = pf, 1 = sc; owner of the current or last frame
reply_pending  out  1  a reply is outstanding

Behaviour:
- States: IDLE, H0, H1, PAY.
- Reset (async): state=IDLE, tx_pins=0, tx_counter=0, reply_pending=0, tx_owner=0, all pulses=0. Reset mid-frame aborts immediately; pins return to 0.
- Eligibility: a requester is eligible when its cmd_valid=1 AND (reply_wanted=0 OR reply_pending=0 OR rx_done=1 this cycle). pf is additionally ineligible while sc_reserve=1.
- Grant is evaluated in IDLE only, combinationally on the inputs. The scheduler wins when both are eligible. The grant cycle asserts x_cmd_started=1 for one cycle. The requester must hold its command and flags stable from the grant cycle through the end of the frame. A valid request is latched into internal registers on grant.
- Granted frames are never preempted.
- Next cycle after grant: H0. tx_pins={1'b1, cmd[2]}.
- H1: tx_pins=cmd[1:0].
- IDLE: tx_pins=2'b00, so the leading 1 in H0 marks the start of a frame.
- If has_payload: PAY for PAYLOAD_CYCLES cycles.
  - tx_pins=owner data.
  - owner x_data_next=1 in every PAY cycle; the data presented in that cycle is what is driven.
  - tx_counter = 0..PAYLOAD_CYCLES-1, incrementing each PAY cycle.
  - tx_done=1 in the last PAY cycle.
- If no payload: tx_done=1 in H1.
- After tx_done, return to IDLE. A new grant may occur in that same IDLE cycle at the earliest, so there is at least 1 idle cycle between frames.
- tx_active=1 in H0, H1, PAY.
- tx_counter holds 0 outside PAY.
- reply_pending:
  - set in the grant cycle+1 (entering H0) when the latched reply_wanted=1.
  - cleared by rx_done.
  - Simultaneous rx_done and a new reply grant: result is 1.
  - rx_done with no reply pending is ignored.
- Latency: request with the bus idle gives started in the same cycle, H0 on the next cycle, and the first payload chunk 3 cycles after the request.

Test Plan:
- sc_cmd_valid=1, cmd=3'b101, has_payload=1, sc_data=counter -> sc_cmd_started at t0; pins 2'b11, 2'b01, then data over 8 cycles; tx_done at t0+10; tx_counter 0..7.
- pf and sc valid in the same cycle -> sc granted; pf granted in the first IDLE cycle after the sc tx_done; pf_data_next never pulses during the sc frame.
- sc_reserve=1, sc_cmd_valid=0, pf_cmd_valid=1 -> no grant; deassert sc_reserve -> pf_cmd_started in that cycle.
- pf frame with reply_wanted=1, then sc reply-wanting request -> sc stalled with reply_pending=1; rx_done pulse -> sc granted in the same cycle; reply_pending remains 1.
- Command with has_payload=0 -> frame is H0, H1 only, tx_done in H1, no data_next pulses.
- Assert reset in PAY cycle 4 -> tx_active=0, tx_pins=0, reply_pending=0 immediately; a new request is granted normally after reset is released.
